// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Optional end-of-memory halt is enabled by defining IFETCH_HALT_EN.
package instruction_fetch_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 32;

    // Bubble word: opcode 010000, rs 01111, rt 0, offset 0.
    localparam logic [INSTR_W-1:0] IF_NOP_WORD = 32'h41E0_0000;

    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundles the memory, control and IF/ID signals of the fetch stage.
// slave: the fetch stage itself; master: whatever drives memory data and control.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [ADDR_W-1:0]  Addr;
    logic [INSTR_W-1:0] Instruction;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic               if_id_valid;
    logic [15:0]        fetch_count;
    logic               halted;

    modport slave (
        output Addr,
        input  Instruction,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid,
        output fetch_count,
        output halted
    );

    modport master (
        input  Addr,
        output Instruction,
        output stall,
        output branch_taken,
        output branch_target,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid,
        input  fetch_count,
        input  halted
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect/hold/increment and RUN/HALT state machine.
// Halt at the last word is built only when IFETCH_HALT_EN is defined; otherwise PC wraps.
module fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 10'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_en
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fetch_en = 1'b0;
        if (branch_taken) begin
            pc_d    = branch_target;
            state_d = StRun;
        end else if (!stall && state_q == StRun) begin
            fetch_en = 1'b1;
`ifdef IFETCH_HALT_EN
            if (pc_q == PC_LAST) begin
                state_d = StHalt;
            end else begin
                pc_d = pc_q + 1'b1;
            end
`else
            pc_d = pc_q + 1'b1;
`endif
        end
    end

    assign pc = pc_q;

`ifdef IFETCH_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage top: PC sub-block plus IF/ID pipeline register and saturating fetch counter.
// Define IFETCH_HALT_EN to stop fetching after the word at the last address.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = 10'd0,
    parameter logic [INSTR_W-1:0] NOP_WORD = IF_NOP_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.slave   bus
);

    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic               fetch_en;

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  ifpc_q;
    logic               valid_q;
    logic [15:0]        count_q;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .pc            (pc),
        .halted        (halted),
        .fetch_en      (fetch_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else if (bus.branch_taken) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else if (bus.stall) begin
            instr_q <= instr_q;
        end else if (fetch_en) begin
            instr_q <= bus.Instruction;
            ifpc_q  <= pc;
            valid_q <= 1'b1;
            count_q <= count_q + 16'(count_q != 16'hFFFF);
        end else begin
            // Halted: keep feeding bubbles downstream.
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end
    end

    assign bus.Addr        = pc;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifpc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_count = count_q;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a rule-level reference model.
// Memory returns 32'hA000_0000 + Addr; halt checks are active when IFETCH_HALT_EN is defined.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h41E0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state, plain integers.
    int m_pc, m_ifpc, m_valid, m_cnt, m_halt;
    int unsigned m_instr;

`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    instruction_fetch_if bus_if ();

    instruction_fetch #(
        .RESET_PC (10'd0),
        .NOP_WORD (32'h41E0_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    assign bus_if.Instruction = 32'hA000_0000 + 32'(bus_if.Addr);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit b, input int tgt);
        if (r) begin
            m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 0; m_cnt = 0; m_halt = 0;
        end else if (b) begin
            m_pc = tgt; m_instr = NOP; m_valid = 0; m_halt = 0;
        end else if (s) begin
            // everything holds
        end else if (m_halt != 0) begin
            m_instr = NOP; m_valid = 0;
        end else begin
            m_instr = 32'hA000_0000 + m_pc;
            m_ifpc  = m_pc;
            m_valid = 1;
            m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (HALT_EN && m_pc == 1023) m_halt = 1;
            else m_pc = (m_pc + 1) % 1024;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  32'(bus_if.Addr),        32'(m_pc));
        check({tag, ".instr"}, bus_if.if_id_instr,      m_instr);
        check({tag, ".ifpc"},  32'(bus_if.if_id_pc),    32'(m_ifpc));
        check({tag, ".valid"}, 32'(bus_if.if_id_valid), 32'(m_valid));
        check({tag, ".count"}, 32'(bus_if.fetch_count), 32'(m_cnt));
        check({tag, ".halt"},  32'(bus_if.halted),      32'(m_halt));
    endtask

    // Apply inputs, take one edge, advance the model, sample 1 time unit later.
    task automatic cycle(input string tag, input bit r, input bit s, input bit b, input int tgt);
        rst                  = r;
        bus_if.stall         = s;
        bus_if.branch_taken  = b;
        bus_if.branch_target = 10'(tgt);
        @(posedge clk);
        model_step(r, s, b, tgt);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus_if.stall = 1'b0;
        bus_if.branch_taken = 1'b0;
        bus_if.branch_target = '0;
        @(negedge clk);

        // Reset for three cycles, then first fetch.
        for (int i = 0; i < 3; i++) cycle("reset", 1, 0, 0, 0);
        check("reset_addr", 32'(bus_if.Addr), 32'd0);
        cycle("first", 0, 0, 0, 0);
        check("first_instr", bus_if.if_id_instr, 32'hA000_0000);
        check("first_addr",  32'(bus_if.Addr), 32'd1);
        check("first_count", 32'(bus_if.fetch_count), 32'd1);

        // Run to PC=5, stall two cycles, resume.
        for (int i = 0; i < 4; i++) cycle("run", 0, 0, 0, 0);
        check("pre_stall_addr", 32'(bus_if.Addr), 32'd5);
        for (int i = 0; i < 2; i++) cycle("stall", 0, 1, 0, 0);
        check("stall_addr", 32'(bus_if.Addr), 32'd5);
        cycle("resume", 0, 0, 0, 0);
        check("resume_instr", bus_if.if_id_instr, 32'hA000_0005);

        // Branch together with stall.
        cycle("br_stall", 0, 1, 1, 200);
        check("br_addr",  32'(bus_if.Addr), 32'd200);
        check("br_instr", bus_if.if_id_instr, NOP);
        check("br_valid", 32'(bus_if.if_id_valid), 32'd0);
        cycle("after_br", 0, 0, 0, 0);
        check("after_br_ifpc", 32'(bus_if.if_id_pc), 32'd200);

        // Reset wins over a branch.
        cycle("rst_br", 1, 0, 1, 300);
        check("rst_br_addr",  32'(bus_if.Addr), 32'd0);
        check("rst_br_count", 32'(bus_if.fetch_count), 32'd0);

        // End of memory: wrap or halt.
        cycle("to_end", 0, 0, 1, 1022);
        cycle("f1022", 0, 0, 0, 0);
        check("f1022_ifpc", 32'(bus_if.if_id_pc), 32'd1022);
        cycle("f1023", 0, 0, 0, 0);
        check("f1023_ifpc", 32'(bus_if.if_id_pc), 32'd1023);
        cycle("after_end", 0, 0, 0, 0);
        if (HALT_EN) begin
            check("halt_flag",  32'(bus_if.halted), 32'd1);
            check("halt_valid", 32'(bus_if.if_id_valid), 32'd0);
            check("halt_addr",  32'(bus_if.Addr), 32'd1023);
            cycle("halt_br", 0, 0, 1, 7);
            check("unhalt_flag", 32'(bus_if.halted), 32'd0);
            check("unhalt_addr", 32'(bus_if.Addr), 32'd7);
        end else begin
            check("wrap_ifpc",  32'(bus_if.if_id_pc), 32'd0);
            check("wrap_halt",  32'(bus_if.halted), 32'd0);
        end

        // Random traffic, targets biased toward the end of memory.
        for (int i = 0; i < 600; i++) begin
            bit r, s, b;
            int tgt;
            r   = ($urandom_range(63) == 0);
            s   = ($urandom_range(3) == 0);
            b   = ($urandom_range(7) == 0);
            tgt = ($urandom_range(1) == 0) ? int'($urandom_range(1023, 1016))
                                           : int'($urandom_range(1023));
            cycle("rand", r, s, b, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
